gba_rom_master: RTL and testbench

- GBA cartridge-bus initiator: plays the console's side of the ROM read protocol against a real cartridge or a cartridge-emulating responder.
- Takes burst read commands (halfword address + length) on a valid/ready interface and generates nCS/nRD/AD/A pin activity with programmable timing.
- Returns each halfword on a registered, back-pressurable stream.
- Used by the cart-dump path and as the bus driver in cartridge-side bring-up benches.

---
 rtl/gba_rom_master_if.sv | 32 +++
 rtl/gba_rom_master.sv | 162 ++++++++++++++++
 tb/tb_gba_rom_master.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gba_rom_master_if.sv
// Command, read-stream and cartridge-pin bundle for gba_rom_master.
// The master modport is the initiator's view; slave is the consumer/cartridge view.
interface gba_rom_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        busy;
    logic        gba_ncs;
    logic        gba_nrd;
    logic [15:0] gba_ad_o;
    logic        gba_ad_oe;
    logic [15:0] gba_ad_i;
    logic [7:0]  gba_a_o;
    logic        gba_a_oe;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, rd_ready, gba_ad_i,
        output cmd_ready, rd_valid, rd_data, rd_last, busy,
               gba_ncs, gba_nrd, gba_ad_o, gba_ad_oe, gba_a_o, gba_a_oe
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, rd_ready, gba_ad_i,
        input  cmd_ready, rd_valid, rd_data, rd_last, busy,
               gba_ncs, gba_nrd, gba_ad_o, gba_ad_oe, gba_a_o, gba_a_oe
    );
endinterface

// File: rtl/gba_rom_master.sv
// GBA cartridge ROM read initiator: turns burst commands into nCS/nRD/AD/A
// pin sequences and returns each halfword on a back-pressurable stream.
module gba_rom_master #(
    parameter int T_SETUP = 2,
    parameter int T_HOLD  = 2,
    parameter int T_N     = 4,
    parameter int T_S     = 2,
    parameter int T_GAP   = 2,
    parameter int T_END   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    gba_rom_master_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_CSLO, S_TURN, S_RD, S_GAP, S_END
    } state_t;

    localparam logic [11:0] SETUP_M1 = 12'(T_SETUP - 1);
    localparam logic [11:0] HOLD_M1  = 12'(T_HOLD - 1);
    localparam logic [11:0] N_M1     = 12'(T_N - 1);
    localparam logic [11:0] S_M1     = 12'(T_S - 1);
    localparam logic [11:0] GAP_M1   = 12'(T_GAP - 1);
    localparam logic [11:0] END_M1   = 12'(T_END - 1);

    state_t      state_q, state_d;
    logic [23:0] cur_addr_q, cur_addr_d;
    logic [8:0]  remaining_q, remaining_d;
    logic [11:0] timer_q, timer_d;
    logic        first_q, first_d;
    logic        rd_valid_q, rd_valid_d;
    logic        rd_last_q, rd_last_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        ncs_q, ncs_d;
    logic        nrd_q, nrd_d;
    logic [15:0] ad_o_q, ad_o_d;
    logic        ad_oe_q, ad_oe_d;
    logic [7:0]  a_o_q, a_o_d;
    logic        a_oe_q, a_oe_d;

    logic        slot_free;
    logic [11:0] rd_len_m1;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        timer_d     = (timer_q == 12'hFFF) ? timer_q : timer_q + 12'd1;
        first_d     = first_q;
        rd_valid_d  = rd_valid_q && !bus.rd_ready;
        rd_last_d   = rd_last_q;
        rd_data_d   = rd_data_q;
        slot_free   = !rd_valid_q || bus.rd_ready;
        rd_len_m1   = first_q ? N_M1 : S_M1;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (bus.cmd_valid) begin
                    cur_addr_d  = bus.cmd_addr;
                    remaining_d = (bus.cmd_len == 8'd0) ? 9'd256 : {1'b0, bus.cmd_len};
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: if (timer_q >= SETUP_M1) begin
                state_d = S_CSLO;
                timer_d = '0;
            end
            S_CSLO: if (timer_q >= HOLD_M1) begin
                state_d = S_TURN;
                timer_d = '0;
                first_d = 1'b1;
            end
            // Waiting here for a free slot guarantees the capture never overwrites
            S_TURN: begin
                timer_d = '0;
                if (slot_free) state_d = S_RD;
            end
            S_RD: if (timer_q >= rd_len_m1) begin
                rd_data_d   = bus.gba_ad_i;
                rd_valid_d  = 1'b1;
                rd_last_d   = (remaining_q == 9'd1);
                remaining_d = remaining_q - 9'd1;
                cur_addr_d  = cur_addr_q + 24'd1;
                first_d     = 1'b0;
                timer_d     = '0;
                if (remaining_q == 9'd1 || cur_addr_d[15:0] == 16'd0)
                    state_d = S_END;
                else
                    state_d = S_GAP;
            end
            S_GAP: if (timer_q >= GAP_M1 && slot_free) begin
                state_d = S_RD;
                timer_d = '0;
            end
            S_END: if (timer_q >= END_M1) begin
                if (remaining_q != 9'd0) begin
                    state_d = S_ADDR;
                    timer_d = '0;
                end else if (slot_free) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pins are registered from the next state so they track state_q exactly
        ncs_d   = !(state_d inside {S_CSLO, S_TURN, S_RD, S_GAP});
        nrd_d   = (state_d != S_RD);
        ad_oe_d = (state_d inside {S_ADDR, S_CSLO});
        a_oe_d  = (state_d inside {S_ADDR, S_CSLO, S_TURN, S_RD, S_GAP});
        ad_o_d  = (state_d == S_ADDR) ? cur_addr_d[15:0]  : ad_o_q;
        a_o_d   = (state_d == S_ADDR) ? cur_addr_d[23:16] : a_o_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            first_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
            ncs_q       <= 1'b1;
            nrd_q       <= 1'b1;
            ad_o_q      <= '0;
            ad_oe_q     <= 1'b0;
            a_o_q       <= '0;
            a_oe_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            first_q     <= first_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
            ncs_q       <= ncs_d;
            nrd_q       <= nrd_d;
            ad_o_q      <= ad_o_d;
            ad_oe_q     <= ad_oe_d;
            a_o_q       <= a_o_d;
            a_oe_q      <= a_oe_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.gba_ncs   = ncs_q;
    assign bus.gba_nrd   = nrd_q;
    assign bus.gba_ad_o  = ad_o_q;
    assign bus.gba_ad_oe = ad_oe_q;
    assign bus.gba_a_o   = a_o_q;
    assign bus.gba_a_oe  = a_oe_q;
endmodule

// File: tb/tb_gba_rom_master.sv
// Bench for gba_rom_master: cartridge responder model, pin-timing monitor and
// a scoreboard of expected halfwords driven from a table of burst commands.
module tb_gba_rom_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gba_rom_master_if bus();

    gba_rom_master dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  len;
        bit          cmode;
        bit          bp;
    } vec_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    bit          const_mode = 1'b0;
    logic [23:0] resp_addr = '0;
    logic        prev_ncs = 1'b1;
    int          n_falls = 0;
    int          n_acc = 0;
    int          width = 0;
    int          widths[1024];
    logic [23:0] seg_addr[16];
    int          words_got = 0;
    int          bp_req = 0;
    int          bp_served = 0;
    int          bp_left = 0;

    assign bus.gba_ad_i = const_mode ? 16'hBEEF : resp_addr[15:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Responder, pin monitor, consumer with backpressure, scoreboard drain
    always @(negedge clk) begin
        if (!bus.gba_ncs && prev_ncs) begin
            seg_addr[n_falls % 16] = {bus.gba_a_o, bus.gba_ad_o};
            resp_addr = {bus.gba_a_o, bus.gba_ad_o};
            n_falls++;
        end
        prev_ncs = bus.gba_ncs;
        if (!bus.gba_nrd) width++;
        else if (width != 0) begin
            widths[n_acc % 1024] = width;
            n_acc++;
            resp_addr = resp_addr + 24'd1;
            width = 0;
        end

        if (!rst_n) bus.rd_ready = 1'b1;
        else if (bp_req != bp_served && bus.rd_valid && bus.rd_ready) begin
            bus.rd_ready = 1'b0;
            bp_left = 10;
            bp_served = bp_req;
        end else if (!bus.rd_ready) begin
            check("bp_nrd_high", bus.gba_nrd, 1'b1);
            check("bp_ncs_low", bus.gba_ncs, 1'b0);
            bp_left--;
            if (bp_left == 0) bus.rd_ready = 1'b1;
        end

        if (rst_n && bus.rd_valid && bus.rd_ready) begin
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_data", bus.rd_data, e.data);
                check("rd_last", bus.rd_last, e.last);
            end
            words_got++;
        end
    end

    task automatic issue(input logic [23:0] addr, input logic [7:0] len);
        int c;
        @(posedge clk) #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.cmd_ready && c < 1000);
        if (c >= 1000) check("cmd_ready_timeout", 1, 0);
        @(posedge clk) #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n, nseg, f0, a0, w0, c;
        int exp_w[256];
        logic [23:0] exp_seg[16];
        logic [23:0] a;
        bit first;
        const_mode = v.cmode;
        n = (v.len == 8'd0) ? 256 : int'(v.len);
        a = v.addr;
        nseg = 0;
        for (int i = 0; i < n; i++) begin
            first = (i == 0) || (a[15:0] == 16'd0);
            if (first) begin
                exp_seg[nseg % 16] = a;
                nseg++;
            end
            exp_w[i] = first ? 4 : 2;
            sb.push_back('{data: (v.cmode ? 16'hBEEF : a[15:0]), last: (i == n - 1)});
            a = a + 24'd1;
        end
        f0 = n_falls;
        a0 = n_acc;
        w0 = words_got;
        if (v.bp) bp_req++;
        issue(v.addr, v.len);
        c = 0;
        while ((bus.busy || sb.size() != 0 || bus.rd_valid) && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 5000) check("done_timeout", 1, 0);
        @(negedge clk);
        check("ncs_falls", n_falls - f0, nseg);
        check("nrd_pulses", n_acc - a0, n);
        check("words", words_got - w0, n);
        check("cmd_ready_idle", bus.cmd_ready, 1'b1);
        for (int i = 0; i < n && i < n_acc - a0; i++)
            check("nrd_width", widths[(a0 + i) % 1024], exp_w[i]);
        for (int s = 0; s < nseg && s < n_falls - f0; s++)
            check("seg_addr", seg_addr[(f0 + s) % 16], exp_seg[s % 16]);
    endtask

    vec_t vt[7];

    initial begin
        int c, a0;
        vt[0] = '{addr: 24'h000010, len: 8'd1,  cmode: 1'b1, bp: 1'b0};
        vt[1] = '{addr: 24'h001000, len: 8'd4,  cmode: 1'b0, bp: 1'b0};
        vt[2] = '{addr: 24'h001000, len: 8'd4,  cmode: 1'b0, bp: 1'b1};
        vt[3] = '{addr: 24'h03FFFE, len: 8'd4,  cmode: 1'b0, bp: 1'b0};
        vt[4] = '{addr: 24'h000000, len: 8'd0,  cmode: 1'b0, bp: 1'b0};
        vt[5] = '{addr: 24'h7FFFF0, len: 8'd20, cmode: 1'b0, bp: 1'b1};
        vt[6] = '{addr: 24'hFFFFFF, len: 8'd2,  cmode: 1'b0, bp: 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        repeat (3) @(negedge clk);
        check("rst_ncs", bus.gba_ncs, 1'b1);
        check("rst_nrd", bus.gba_nrd, 1'b1);
        check("rst_ad_oe", bus.gba_ad_oe, 1'b0);
        check("rst_a_oe", bus.gba_a_oe, 1'b0);
        check("rst_ad_o", bus.gba_ad_o, 16'h0);
        check("rst_a_o", bus.gba_a_o, 8'h0);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_rd_last", bus.rd_last, 1'b0);
        check("rst_rd_data", bus.rd_data, 16'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Reset asserted while the third nRD pulse of a burst is low
        const_mode = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 4; i++)
            sb.push_back('{data: 16'h0100 + 16'(i), last: (i == 3)});
        issue(24'h000100, 8'd4);
        c = 0;
        while (!(n_acc == a0 + 2 && !bus.gba_nrd) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 1000) check("third_rd_timeout", 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ncs", bus.gba_ncs, 1'b1);
        check("arst_nrd", bus.gba_nrd, 1'b1);
        check("arst_rd_valid", bus.rd_valid, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_a_oe", bus.gba_a_oe, 1'b0);
        sb.delete();
        repeat (3) @(negedge clk);
        check("arst_no_data", bus.rd_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
        run_vec('{addr: 24'h000020, len: 8'd1, cmode: 1'b1, bp: 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
